// File: rtl/prog_loader.sv
// UART-loadable 16x8 program memory that replaces the CPU's fixed ROM.
// Frame: header byte, 2**ADDR_W data bytes, then an 8-bit additive checksum.
module prog_loader #(
    parameter int          CLK_HZ = 50_000_000,
    parameter int          BAUD   = 115200,
    parameter int          ADDR_W = 4,
    parameter int          PROG_W = 8,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              rx,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [PROG_W-1:0] prog_data,
    output logic              cpu_hold,
    output logic              loading,
    output logic              done,
    output logic              err
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYC / 2 - 1);

    typedef struct packed {
        logic       valid;
        logic       ferr;
        logic [7:0] data;
    } rx_evt_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, WAIT_HDR, DATA, CHECK, ERROR} state_t;

    // ---------------- UART receiver ----------------
    logic [1:0]       rx_sync;
    logic             rx_s, rx_prev;
    rx_state_t        rx_st, rx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_n, bit_nxt;
    logic [7:0]       sh, sh_nxt;
    rx_evt_t          evt, evt_nxt;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (RST) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            rx_st   <= RX_IDLE;
            cnt     <= '0;
            bit_n   <= '0;
            sh      <= '0;
            evt     <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
            rx_st   <= rx_nxt;
            cnt     <= cnt_nxt;
            bit_n   <= bit_nxt;
            sh      <= sh_nxt;
            evt     <= evt_nxt;
        end
    end

    // Start bit is re-checked at mid-bit; a short low glitch drops back to idle.
    always_comb begin
        rx_nxt  = rx_st;
        cnt_nxt = cnt + 1'b1;
        bit_nxt = bit_n;
        sh_nxt  = sh;
        evt_nxt = '0;
        case (rx_st)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_s) rx_nxt = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt = '0;
                    bit_nxt = '0;
                    rx_nxt  = rx_s ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rx_s, sh[7:1]};
                    bit_nxt = bit_n + 3'd1;
                    if (bit_n == 3'd7) rx_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt       = '0;
                    rx_nxt        = RX_IDLE;
                    evt_nxt.valid = rx_s;
                    evt_nxt.ferr  = !rx_s;
                    evt_nxt.data  = sh;
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // ---------------- load FSM + memory ----------------
    state_t                       st, st_nxt;
    logic [ADDR_W-1:0]            idx;
    logic [7:0]                   sum;
    logic [DEPTH-1:0][PROG_W-1:0] mem;
    logic                         restart, wr_en, set_err;

    always_ff @(posedge clk) begin
        if (RST) begin
            st  <= IDLE;
            idx <= '0;
            sum <= '0;
            err <= 1'b0;
            mem <= '0;
        end else begin
            st <= st_nxt;
            if (restart) begin
                idx <= '0;
                sum <= '0;
                err <= 1'b0;
            end
            if (set_err) err <= 1'b1;
            if (wr_en) begin
                mem[idx] <= PROG_W'(evt.data);
                sum      <= sum + evt.data;
                idx      <= idx + 1'b1;
            end
        end
    end

    // load_req has priority over any received byte or framing error.
    always_comb begin
        st_nxt  = st;
        restart = 1'b0;
        wr_en   = 1'b0;
        set_err = 1'b0;
        done    = 1'b0;
        if (load_req) begin
            st_nxt  = WAIT_HDR;
            restart = 1'b1;
        end else if (evt.ferr && (st == WAIT_HDR || st == DATA || st == CHECK)) begin
            st_nxt  = ERROR;
            set_err = 1'b1;
        end else if (evt.valid) begin
            case (st)
                WAIT_HDR: if (evt.data == HDR) st_nxt = DATA;
                DATA: begin
                    wr_en = 1'b1;
                    if (&idx) st_nxt = CHECK;
                end
                CHECK: begin
                    if (evt.data == sum) begin
                        done   = 1'b1;
                        st_nxt = IDLE;
                    end else begin
                        set_err = 1'b1;
                        st_nxt  = ERROR;
                    end
                end
                default: st_nxt = st;
            endcase
        end
    end

    assign prog_data = mem[cpu_addr];
    assign loading   = (st == WAIT_HDR) || (st == DATA) || (st == CHECK);
    assign cpu_hold  = (st != IDLE) || err;
endmodule
